// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: fetch FSM states and the buffered fetch entry.
package rv32i_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues imem requests, buffers returned words for decode.
//   state | meaning
//   IDLE  | nothing outstanding at memory
//   WAIT  | one granted request outstanding, response will be kept
//   DROP  | one granted request outstanding, response will be discarded
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e   state_q, state_d;
  logic [31:0]    pc_q, req_pc_q, pend_addr_q;
  logic           pend_q, stale_q;
  logic [CW-1:0]  fifo_count, count_after;
  logic           fifo_full, fifo_empty;
  logic           push, pop, granted, drop_grant, new_req;
  fetch_entry_t   wr_entry, head;
  logic           unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign pop  = id_valid && id_ready;
  assign push = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  // Occupancy after this edge; a new request may issue if its response will fit.
  assign count_after = redirect_valid ? '0 : fifo_count + CW'(push) - CW'(pop);
  assign new_req     = ((state_q == IDLE) || imem_rvalid) && (count_after < DEPTH_C);

  // A pending request holds its original address even if a redirect moved pc_q.
  assign imem_req   = !rst && (pend_q || new_req);
  assign imem_addr  = pend_q ? pend_addr_q : pc_q;
  assign granted    = imem_req && imem_gnt;
  assign drop_grant = redirect_valid || stale_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (granted) state_d = drop_grant ? DROP : WAIT;
      WAIT, DROP: begin
        if (imem_rvalid)         state_d = granted ? (drop_grant ? DROP : WAIT) : IDLE;
        else if (redirect_valid) state_d = DROP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= imem_req && !imem_gnt;
      stale_q <= imem_req && !imem_gnt && (stale_q || redirect_valid);
      if (imem_req && !imem_gnt) pend_addr_q <= imem_addr;
      if (granted) req_pc_q <= imem_addr;
      // A stale grant fetched the old address; pc_q already holds the redirect target.
      if (redirect_valid)          pc_q <= {redirect_pc[31:2], 2'b00};
      else if (granted && !stale_q) pc_q <= pc_q + 32'd4;
    end
  end

  assign wr_entry = '{pc: req_pc_q, instr: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign id_valid = !fifo_empty;
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

`ifndef SYNTHESIS
  a_rvalid_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && state_q == IDLE))
    else $error("imem_rvalid with no request outstanding");
  a_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full))
    else $error("fetch buffer overflow");
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- RV32I instruction fetch stage, directly upstream of instruction decode.
- Owns the PC and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (taken branch, jal, jalr) from execute: flushes the FIFO and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address; bits [1:0] always 00.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid; in order, at least 1 cycle after its gnt.
- imem_rdata  input  32  returned instruction word.
- redirect_valid  input  1  control-flow change; single-cycle pulse.
- redirect_pc  input  32  new PC; bits [1:0] ignored (misalignment is trapped in execute).
- id_valid  output  1  FIFO head is valid.
- id_ready  input  1  decode accepts the head.
- id_instr  output  32  head instruction word, consumed by decode.
- id_pc  output  32  PC of the head instruction.

Behaviour:
- Reset values: pc_q=RESET_PC, state=IDLE, FIFO empty, imem_req=0, id_valid=0, id_instr=NOP (32'h0000_0013), id_pc=0.
- Reset asserted mid-operation clears everything immediately. Memory responses already in flight are not tracked after reset; the system resets memory together with this block.
- At most one request outstanding between gnt and its rvalid.
- Issue condition: imem_req=1 when (state==IDLE, or rvalid arrives this cycle) and (fifo_count + outstanding_kept) < FIFO_DEPTH. imem_addr=pc_q.
- Once asserted, imem_req and imem_addr stay stable until gnt; no retraction.
- A redirect while req is pending and ungranted marks that request stale: its eventual response is dropped.
- On gnt: req_pc_q<=pc_q; pc_q<=pc_q+4, wrapping modulo 2^32.
- Redirect has priority for the PC: pc_q<={redirect_pc[31:2],2'b00}, including when gnt occurs in the same cycle.
- FSM:
  - IDLE: nothing outstanding. gnt without redirect -> WAIT. gnt with redirect, or a stale pending request granted -> DROP.
  - WAIT: response will be kept. On rvalid, push {req_pc_q, imem_rdata} unless redirect_valid in the same cycle (then drop it). Then: new gnt -> WAIT or DROP per the same rule; otherwise -> IDLE. redirect_valid without rvalid -> DROP.
  - DROP: on rvalid, discard the data. Then: new gnt -> WAIT (or DROP if redirect) ; otherwise -> IDLE.
- imem_rvalid in IDLE is a protocol violation. It is ignored and flagged by a simulation assertion.
- FIFO:
  - Push and pop may occur in the same cycle.
  - Issue accounting guarantees no push when full.
  - Pop occurs on id_valid && id_ready.
  - redirect_valid clears the FIFO at the next edge; flush wins over a same-cycle push or pop. Decode must treat a handshake in the redirect cycle as killed.
- Outputs id_valid, id_instr and id_pc come from FIFO registers, with no combinational path from imem_rdata.
- Latency:
  - rvalid at cycle t -> id_valid at t+1.
  - redirect at t -> imem_addr=redirect_pc at t+1 at the earliest.
  - Zero-wait memory (gnt same cycle, rvalid next) with id_ready=1 sustains 1 instruction per cycle.

Decomposition:
- rv32i_pkg holds:
  - XLEN=32 and NOP_INSTR=32'h0000_0013;
  - typedef enum fetch_state_e {IDLE, WAIT, DROP};
  - typedef struct packed fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with flush, count and full/empty outputs, using the same clk/rst.

Test Plan:
- Reset release, zero-wait memory returning word = addr ^ 32'hA5A5_0000, id_ready=1 -> imem_addr sequence 0,4,8,12. id_pc/id_instr match in order, one per cycle from the 3rd cycle after reset release.
- id_ready=0 for 10 cycles -> exactly FIFO_DEPTH (2) entries buffered, imem_req=0 afterwards, no lost or duplicated PCs when id_ready returns to 1.
- gnt for addr 8, redirect to 32'h0000_0100 before its rvalid -> the response for 8 is never presented. The next id_pc after the flush is 0x100, then 0x104.
- redirect to 32'h0000_0203 in the same cycle as rvalid and a new gnt -> that data is dropped, the new request is also dropped, and the next fetch address is 0x200.
- imem_gnt held low 5 cycles with a redirect in cycle 2 -> imem_addr stable until gnt, that response dropped, the next request goes to the redirect PC.
- rst asserted while in WAIT with a full FIFO -> id_valid=0 and imem_req=0 immediately. After release, fetch restarts at RESET_PC.
